// File: rtl/bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fifo_ctrl
//
// Single-clock FIFO controller for an external inferred BRAM. The BRAM has a
// registered read with no read enable, so the data lands one cycle after the
// read address. This block generates the BRAM addresses and write enable. It
// hides the read latency behind a 2-entry skid buffer, so the consumer sees
// first-word-fall-through valid/ready behaviour.
//
// Ports
//   i_clk        clock (BRAM read and write clocks tied to it)
//   i_reset_n    synchronous active-low reset
//   i_flush      synchronous clear of pointers/buffers, BRAM contents untouched
//   i_wr_valid   producer word valid
//   o_wr_ready   controller accepts a word this cycle (registered state only)
//   i_wr_data    producer word
//   o_rd_valid   head word present on o_rd_data
//   i_rd_ready   consumer takes the head word
//   o_rd_data    head word
//   o_count      words held: BRAM + in-flight read + skid, 0..P_DEPTH+2
//   o_empty      o_count == 0
//   o_mem_we     BRAM write enable
//   o_mem_waddr  BRAM write address
//   o_mem_wdata  BRAM write data
//   o_mem_raddr  BRAM read address
//   i_mem_rdata  BRAM registered read data
// -----------------------------------------------------------------------------
module bram_fifo_ctrl #(
  parameter int P_DATA_MSB    = 15,
  parameter int P_ADDRESS_MSB = 4,
  parameter int P_DEPTH       = 32   // must equal 2**(P_ADDRESS_MSB+1)
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_flush,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [P_DATA_MSB:0]      i_wr_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [P_DATA_MSB:0]      o_rd_data,
  output logic [P_ADDRESS_MSB+1:0] o_count,
  output logic                     o_empty,
  output logic                     o_mem_we,
  output logic [P_ADDRESS_MSB:0]   o_mem_waddr,
  output logic [P_DATA_MSB:0]      o_mem_wdata,
  output logic [P_ADDRESS_MSB:0]   o_mem_raddr,
  input  logic [P_DATA_MSB:0]      i_mem_rdata
);

  localparam int AW = P_ADDRESS_MSB + 1;  // address width
  localparam int CW = P_ADDRESS_MSB + 2;  // count width, holds 0..P_DEPTH+2
  localparam int DW = P_DATA_MSB + 1;     // data width

  // Pointers wrap naturally at P_DEPTH because P_DEPTH is a power of two.
  // mem_count tells full from empty, so no extra wrap bit is needed.
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_count;   // words resident in BRAM, not yet read out
  logic          inflight;    // read issued last cycle, data on i_mem_rdata now
  logic [CW-1:0] count;

  // Skid buffer: two entries, indexed by single-bit head/tail pointers.
  logic [DW-1:0] skid_mem [2];
  logic          skid_head;
  logic          skid_tail;
  logic [1:0]    skid_count;

  logic          accept;
  logic          pop;
  logic          issue;
  logic [2:0]    skid_claimed;

  assign o_wr_ready = (mem_count < CW'(P_DEPTH));

  // A word offered during reset or flush would be wiped in the same edge.
  // Gating it here keeps the BRAM write strobe quiet in those cycles.
  assign accept = i_wr_valid & o_wr_ready & i_reset_n & ~i_flush;
  assign pop    = o_rd_valid & i_rd_ready;

  // Issue a read only if the skid has room for the returning word. Count the
  // words already in the skid, plus the word in flight, minus the word leaving
  // this cycle.
  assign skid_claimed = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue        = (mem_count != '0) && (skid_claimed < 3'd2);

  assign o_mem_we    = accept;
  assign o_mem_waddr = wr_ptr;
  assign o_mem_wdata = i_wr_data;
  assign o_mem_raddr = rd_ptr;

  assign o_rd_valid = (skid_count != 2'd0);
  assign o_rd_data  = skid_mem[skid_head];
  assign o_count    = count;
  assign o_empty    = (count == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      inflight   <= 1'b0;   // drops the word a pending BRAM read returns
      count      <= '0;
      skid_head  <= 1'b0;
      skid_tail  <= 1'b0;
      skid_count <= 2'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (issue)  rd_ptr <= rd_ptr + AW'(1);
      inflight   <= issue;
      mem_count  <= mem_count + CW'(accept) - CW'(issue);
      count      <= count + CW'(accept) - CW'(pop);
      if (inflight) skid_tail <= ~skid_tail;
      if (pop)      skid_head <= ~skid_head;
      skid_count <= skid_count + 2'(inflight) - 2'(pop);
    end
  end

  // NOTE: the skid data storage is deliberately not reset. skid_count decides
  // validity, so stale contents are never presented. Leaving the data
  // unreset keeps it out of the reset tree.
  always_ff @(posedge i_clk) begin
    if (inflight) skid_mem[skid_tail] <= i_mem_rdata;
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_fifo_ctrl
//
// Self-checking bench for bram_fifo_ctrl. It has a behavioural BRAM with a
// registered read, and a queue scoreboard. Words are pushed when the producer
// handshake completes. They are popped and compared when the consumer
// handshake completes.
// -----------------------------------------------------------------------------
module tb_bram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [5:0]  count;
  logic        empty;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic [4:0]  mem_raddr;
  logic [15:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sb [$];
  logic [15:0] exp_w;
  logic        did_accept;
  logic        did_pop;
  logic [15:0] last_pop_data;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data;
  logic        we_s;
  logic [4:0]  waddr_s;
  logic [4:0]  raddr_s;
  int          n_recv;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(
    .P_DATA_MSB(15), .P_ADDRESS_MSB(4), .P_DEPTH(32)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_flush(flush),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
    .o_count(count), .o_empty(empty),
    .o_mem_we(mem_we), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
    .o_mem_raddr(mem_raddr), .i_mem_rdata(mem_rdata)
  );

  // Inferred-style BRAM: synchronous write, registered read, no read enable.
  logic [15:0] bram [32];
  always @(posedge clk) begin
    if (mem_we) bram[mem_waddr] <= mem_wdata;
    mem_rdata <= bram[mem_raddr];
  end

  // One clock cycle. Handshakes are sampled on the falling edge, where the
  // inputs driven after the previous rising edge are stable. Then the task
  // advances to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    did_accept = reset_n && !flush && wr_valid && wr_ready;
    did_pop    = reset_n && !flush && rd_valid && rd_ready;
    if (did_accept) sb.push_back(wr_data);
    if (did_pop) begin
      checks++;
      last_pop_data = rd_data;
      n_recv++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_extra_word: got %h, expected no word", rd_data);
      end else begin
        exp_w = sb.pop_front();
        if (rd_data !== exp_w) begin
          failures++;
          $display("FAIL sb_data: got %h, expected %h", rd_data, exp_w);
        end
      end
    end
    if (stall_prev) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== stall_data) begin
        failures++;
        $display("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h",
                 rd_valid, rd_data, stall_data);
      end
    end
    stall_prev = reset_n && !flush && rd_valid && !rd_ready;
    stall_data = rd_data;
    we_s    = mem_we;
    waddr_s = mem_waddr;
    raddr_s = mem_raddr;
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    flush = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    tick();
    flush = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; wr_valid = 1'b1; wr_data = 16'hFFFF; rd_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b, expected 0", mem_we); end
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b, expected 0", rd_valid); end
    checks++;
    if (count !== 6'd0 || empty !== 1'b1) begin
      failures++; $display("FAIL reset_count: got count=%0d empty=%b, expected 0/1", count, empty);
    end
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready: got %b, expected 1", wr_ready); end
    checks++;
    if (mem_waddr !== 5'd0 || mem_raddr !== 5'd0) begin
      failures++; $display("FAIL reset_addr: got w=%0d r=%0d, expected 0/0", mem_waddr, mem_raddr);
    end
    wr_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    sb.delete();
  endtask

  task automatic test_single();
    wr_valid = 1'b1; wr_data = 16'hA5A5; rd_ready = 1'b1;
    tick();                       // E0: word accepted
    wr_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || count !== 6'd1) begin
      failures++; $display("FAIL single_e0: got valid=%b count=%0d, expected 0/1", rd_valid, count);
    end
    tick();                       // E1: read data returning
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_e1: got valid=%b, expected 0", rd_valid); end
    tick();                       // E2: word in skid
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5) begin
      failures++; $display("FAIL single_e2: got valid=%b data=%h, expected 1/a5a5", rd_valid, rd_data);
    end
    tick();                       // E3: consumed
    checks++;
    if (count !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL single_drain: got count=%0d empty=%b valid=%b, expected 0/1/0",
                           count, empty, rd_valid);
    end
  endtask

  task automatic test_fill();
    int budget;
    flush_pulse();
    rd_ready = 1'b0;
    for (int v = 0; v <= 40; v++) begin
      wr_valid = 1'b1; wr_data = 16'(v);
      tick();
    end
    wr_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (sb.size() != 34) begin failures++; $display("FAIL fill_accepted: got %0d, expected 34", sb.size()); end
    checks++;
    if (wr_ready !== 1'b0 || count !== 6'd34 || empty !== 1'b0) begin
      failures++; $display("FAIL fill_full: got ready=%b count=%0d empty=%b, expected 0/34/0",
                           wr_ready, count, empty);
    end
    // Producer pushing against a full controller must not write the BRAM.
    wr_valid = 1'b1; wr_data = 16'hDEAD;
    tick();
    checks++;
    if (mem_we !== 1'b0 || count !== 6'd34) begin
      failures++; $display("FAIL fill_blocked: got we=%b count=%0d, expected 0/34", mem_we, count);
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    budget = 0;
    while (count != 6'd0 && budget < 200) begin tick(); budget++; end
    checks++;
    if (count !== 6'd0 || sb.size() != 0) begin
      failures++; $display("FAIL fill_drain: got count=%0d left=%0d, expected 0/0", count, sb.size());
    end
  endtask

  task automatic test_stream();
    int sent, first, last, w_wraps, r_wraps;
    logic [4:0] prev_raddr;
    flush_pulse();
    sent = 0; first = -1; last = -1; w_wraps = 0; r_wraps = 0; n_recv = 0;
    prev_raddr = 5'd0;
    for (int c = 0; c < 300 && n_recv < 100; c++) begin
      wr_valid = (sent < 100); wr_data = 16'(sent); rd_ready = 1'b1;
      tick();
      if (did_accept) sent++;
      if (did_pop) begin
        if (first < 0) first = c;
        last = c;
      end
      if (we_s && waddr_s == 5'd31) w_wraps++;
      if (prev_raddr == 5'd31 && raddr_s == 5'd0) r_wraps++;
      prev_raddr = raddr_s;
    end
    wr_valid = 1'b0;
    checks++;
    if (n_recv != 100) begin failures++; $display("FAIL stream_count: got %0d, expected 100", n_recv); end
    checks++;
    if (first != 3 || last != 102) begin
      failures++; $display("FAIL stream_timing: got first=%0d last=%0d, expected 3/102", first, last);
    end
    checks++;
    if (w_wraps != 3 || r_wraps != 3) begin
      failures++; $display("FAIL stream_wrap: got w=%0d r=%0d, expected 3/3", w_wraps, r_wraps);
    end
  endtask

  task automatic test_random();
    int sent;
    flush_pulse();
    sent = 0; n_recv = 0;
    for (int c = 0; c < 60000 && n_recv < 10000; c++) begin
      wr_valid = (sent < 10000) && ($urandom_range(3) != 0);
      wr_data  = 16'($urandom);
      rd_ready = ($urandom_range(3) != 0);
      tick();
      if (did_accept) sent++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    checks++;
    if (n_recv != 10000 || sb.size() != 0) begin
      failures++; $display("FAIL random_total: got recv=%0d left=%0d, expected 10000/0", n_recv, sb.size());
    end
    checks++;
    if (count !== 6'd0 || empty !== 1'b1) begin
      failures++; $display("FAIL random_end: got count=%0d empty=%b, expected 0/1", count, empty);
    end
  endtask

  task automatic test_flush();
    int budget;
    flush_pulse();
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 16'h0100 + 16'(i);
      tick();
    end
    wr_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (count !== 6'd5 || rd_valid !== 1'b1) begin
      failures++; $display("FAIL flush_pre: got count=%0d valid=%b, expected 5/1", count, rd_valid);
    end
    rd_ready = 1'b1;
    tick();                       // one pop frees a skid slot, a read issues
    rd_ready = 1'b0;
    flush = 1'b1;
    tick();                       // flush while that read is in flight
    flush = 1'b0;
    sb.delete();
    checks++;
    if (rd_valid !== 1'b0 || count !== 6'd0 || empty !== 1'b1 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL flush_state: got valid=%b count=%0d empty=%b ready=%b, expected 0/0/1/1",
                           rd_valid, count, empty, wr_ready);
    end
    checks++;
    if (mem_waddr !== 5'd0 || mem_raddr !== 5'd0) begin
      failures++; $display("FAIL flush_addr: got w=%0d r=%0d, expected 0/0", mem_waddr, mem_raddr);
    end
    repeat (3) tick();
    checks++;
    if (rd_valid !== 1'b0 || count !== 6'd0) begin
      failures++; $display("FAIL flush_ghost: got valid=%b count=%0d, expected 0/0", rd_valid, count);
    end
    wr_valid = 1'b1; wr_data = 16'h1234; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    n_recv = 0; budget = 0;
    while (n_recv == 0 && budget < 10) begin tick(); budget++; end
    checks++;
    if (n_recv != 1 || last_pop_data !== 16'h1234) begin
      failures++; $display("FAIL flush_next: got recv=%0d data=%h, expected 1/1234", n_recv, last_pop_data);
    end
  endtask

  initial begin
    n_recv = 0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
